// File: rtl/mem_access_stage.sv
// MEM stage: data-memory loads/stores over a req/ack bus, registers the MEM/WB word.
// Define MEM_ACCESS_TIMEOUT_EN to abandon accesses whose ack never arrives.
module mem_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] exmem_reg,
    input  logic         exmem_valid,
    input  logic         flush,
    output logic         mem_stall,
    output logic [127:0] memwr_reg,
    output logic         memwr_valid,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [31:0]  dmem_addr,
    output logic [31:0]  dmem_wdata,
    output logic [3:0]   dmem_be,
    input  logic [31:0]  dmem_rdata,
    input  logic         dmem_ack,
    output logic         mem_err
);
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t       r_state;
    logic [127:0] r_memwr;
    logic         r_valid;
    logic         r_req;
    logic         r_we;
    logic [31:0]  r_addr;
    logic [31:0]  r_wdata;
    logic [3:0]   r_be;
    logic [31:0]  r_inst;
    logic [31:0]  r_alu;
    logic [31:0]  r_pc;
    logic         r_flushed;

    logic [5:0]   w_op;
    logic [31:0]  w_alu;
    logic [31:0]  w_rt;
    logic         w_is_load;
    logic         w_is_store;
    logic         w_is_mem;
    logic         w_is_sb;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata;
    logic [31:0]  w_shift;
    logic [7:0]   w_byte;
    logic [31:0]  w_ldata;
    logic         w_timeout;

    assign w_op       = exmem_reg[31:26];
    assign w_alu      = exmem_reg[63:32];
    assign w_rt       = exmem_reg[95:64];
    assign w_is_load  = (w_op == OP_LW) || (w_op == OP_LB) || (w_op == OP_LBU);
    assign w_is_store = (w_op == OP_SW) || (w_op == OP_SB);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_is_sb    = (w_op == OP_SB);
    assign w_be       = w_is_sb ? (4'b0001 << w_alu[1:0]) : 4'b1111;
    assign w_wdata    = w_is_sb ? {4{w_rt[7:0]}} : (w_is_store ? w_rt : 32'b0);

    // Lane select uses the latched address; upstream may move on in the ack cycle.
    assign w_shift = dmem_rdata >> {r_alu[1:0], 3'b000};
    assign w_byte  = w_shift[7:0];

    always_comb begin
        w_ldata = 32'b0;
        unique case (r_inst[31:26])
            OP_LW:   w_ldata = dmem_rdata;
            OP_LB:   w_ldata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ldata = {24'b0, w_byte};
            default: w_ldata = 32'b0;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] r_cnt;
    logic          r_err;

    assign w_timeout = (r_state == S_ACCESS) && !dmem_ack
                       && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if ((r_state == S_ACCESS) && !dmem_ack && !w_timeout)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign mem_err = r_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign mem_err          = 1'b0;
`endif

    assign mem_stall = ((r_state == S_IDLE) && exmem_valid && w_is_mem)
                     || ((r_state == S_ACCESS) && !dmem_ack && !w_timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_memwr   <= '0;
            r_valid   <= 1'b0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_inst    <= '0;
            r_alu     <= '0;
            r_pc      <= '0;
            r_flushed <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_flushed <= 1'b0;
                    if (exmem_valid && !flush && w_is_mem) begin
                        r_state <= S_ACCESS;
                        r_req   <= 1'b1;
                        r_we    <= w_is_store;
                        r_addr  <= {w_alu[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_inst  <= exmem_reg[31:0];
                        r_alu   <= w_alu;
                        r_pc    <= exmem_reg[127:96];
                        r_valid <= 1'b0;
                    end else if (exmem_valid && !flush) begin
                        r_memwr <= {exmem_reg[127:96], 32'b0, exmem_reg[63:0]};
                        r_valid <= 1'b1;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (flush)
                        r_flushed <= 1'b1;
                    // A flushed access still completes on the bus; only the result is dropped.
                    if (dmem_ack) begin
                        r_req   <= 1'b0;
                        r_memwr <= {r_pc, w_ldata, r_alu, r_inst};
                        r_valid <= !(r_flushed || flush);
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_memwr <= {r_pc, 32'b0, r_alu, r_inst};
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign memwr_reg   = r_memwr;
    assign memwr_valid = r_valid;
    assign dmem_req    = r_req;
    assign dmem_we     = r_we;
    assign dmem_addr   = r_addr;
    assign dmem_wdata  = r_wdata;
    assign dmem_be     = r_be;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: randomized instruction stream, reactive memory
// responder and a transaction-level model checked every cycle, plus directed cases.
module tb_mem_access_stage;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] exmem_reg = '0;
    logic         exmem_valid = 1'b0;
    logic         flush = 1'b0;
    logic         mem_stall;
    logic [127:0] memwr_reg;
    logic         memwr_valid;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic [3:0]   dmem_be;
    logic [31:0]  dmem_rdata = '0;
    logic         dmem_ack = 1'b0;
    logic         mem_err;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .exmem_reg(exmem_reg), .exmem_valid(exmem_valid), .flush(flush),
        .mem_stall(mem_stall),
        .memwr_reg(memwr_reg), .memwr_valid(memwr_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_err(mem_err)
    );

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] opc(input logic [127:0] w);
        return w[31:26];
    endfunction

    function automatic bit is_ld(input logic [127:0] w);
        return opc(w) inside {6'h23, 6'h20, 6'h24};
    endfunction

    function automatic bit is_st(input logic [127:0] w);
        return opc(w) inside {6'h2B, 6'h28};
    endfunction

    function automatic bit is_mem(input logic [127:0] w);
        return is_ld(w) || is_st(w);
    endfunction

    // Loaded value from a little-endian word, lane = address mod 4.
    function automatic logic [31:0] load_val(input logic [127:0] w, input logic [31:0] rd);
        int k;
        logic [31:0] b;
        k = int'(w[33:32]);
        b = (rd >> (8 * k)) & 32'hFF;
        case (opc(w))
            6'h23:   return rd;
            6'h20:   return (b >= 32'd128) ? b - 32'd256 : b;
            6'h24:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [127:0] wb_word(input logic [127:0] w, input logic [31:0] ld);
        return {w[127:96], ld, w[63:32], w[31:0]};
    endfunction

    function automatic logic [3:0] exp_be(input logic [127:0] w);
        if (opc(w) == 6'h28)
            return 4'b0001 << w[33:32];
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [127:0] w);
        if (opc(w) == 6'h28)
            return {24'b0, w[71:64]} * 32'h0101_0101;
        return w[95:64];
    endfunction

    // Reference model: one outstanding transaction at most, results by rule.
    always @(negedge clk) begin : model
        bit busy;
        bit fl;
        bit vld;
        bit es;
        logic [127:0] op;
        logic [127:0] wb;
        es = busy ? !dmem_ack : (exmem_valid && is_mem(exmem_reg));
        if (chk_en) begin
            chk("stall", 128'(mem_stall), 128'(es));
            chk("wb_valid", 128'(memwr_valid), 128'(vld));
            if (vld)
                chk("wb_word", memwr_reg, wb);
            chk("req", 128'(dmem_req), 128'(busy));
            if (busy) begin
                chk("we", 128'(dmem_we), 128'(is_st(op)));
                chk("addr", 128'(dmem_addr), 128'(op[63:32] & ~32'd3));
                chk("be", 128'(dmem_be), 128'(exp_be(op)));
                if (is_st(op))
                    chk("wdata", 128'(dmem_wdata), 128'(exp_wd(op)));
            end
            chk("err", 128'(mem_err), 128'd0);
        end
        if (rst) begin
            busy = 1'b0;
            vld  = 1'b0;
            fl   = 1'b0;
            wb   = '0;
        end else if (busy) begin
            fl = fl | flush;
            if (dmem_ack) begin
                busy = 1'b0;
                wb   = wb_word(op, load_val(op, dmem_rdata));
                vld  = !fl;
            end
        end else if (exmem_valid && !flush) begin
            if (is_mem(exmem_reg)) begin
                busy = 1'b1;
                fl   = 1'b0;
                op   = exmem_reg;
                vld  = 1'b0;
            end else begin
                wb  = wb_word(exmem_reg, 32'd0);
                vld = 1'b1;
            end
        end else begin
            vld = 1'b0;
        end
    end

    int          rsp_delay = 1;
    bit          rsp_rand = 1'b0;
    bit          rsp_en = 1'b1;
    bit          spur_en = 1'b0;
    logic [31:0] rsp_rdata = '0;
    int          n_stores = 0;

    // Memory responder: acks on the dly-th cycle of a request; random noise acks when idle.
    always @(posedge clk) begin : rsp
        int cnt;
        int dly;
        #1;
        if (dmem_req) begin
            if (cnt == 0)
                dly = rsp_rand ? int'($urandom_range(4, 1)) : rsp_delay;
            cnt++;
            if (rsp_en && cnt == dly) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rsp_rand ? $urandom : rsp_rdata;
                if (dmem_we)
                    n_stores++;
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = $urandom;
            end
        end else begin
            cnt        = 0;
            dmem_ack   = spur_en && ($urandom_range(7, 0) == 0);
            dmem_rdata = $urandom;
        end
    end

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic issue(input logic [127:0] w, input bit v, input int fl_at,
                         input bit rfl, output int stalls, output int reqs);
        bit s;
        bit done;
        done = 1'b0;
        exmem_reg = w;
        exmem_valid = v;
        stalls = 0;
        reqs = 0;
        for (int c = 0; c < 64; c++) begin
            flush = rfl ? ($urandom_range(7, 0) == 0) : (c == fl_at);
            @(negedge clk);
            s = mem_stall;
            if (dmem_req) begin
                reqs++;
                cap_addr  = dmem_addr;
                cap_wdata = dmem_wdata;
                cap_be    = dmem_be;
                cap_we    = dmem_we;
            end
            @(posedge clk);
            #1;
            if (!s) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        exmem_valid = 1'b0;
        flush = 1'b0;
        chk("issue_done", 128'(done), 128'd1);
    endtask

    logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h0F, 6'h23, 6'h20, 6'h24, 6'h2B, 6'h28};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        int rq;
        int ns;
        logic [127:0] w;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_memwr", memwr_reg, 128'd0);
        chk("rst_valid", 128'(memwr_valid), 128'd0);
        chk("rst_req", 128'(dmem_req), 128'd0);
        chk("rst_we", 128'(dmem_we), 128'd0);
        chk("rst_addr", 128'(dmem_addr), 128'd0);
        chk("rst_wdata", 128'(dmem_wdata), 128'd0);
        chk("rst_be", 128'(dmem_be), 128'd0);
        chk("rst_err", 128'(mem_err), 128'd0);
        chk("rst_stall", 128'(mem_stall), 128'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        issue({32'h0000_0404, 32'h5555_5555, 32'h0000_1234, 32'h0000_0021}, 1, -1, 0, st, rq);
        chk("addu_stalls", 128'(st), 128'd0);
        chk("addu_word", memwr_reg, {32'h0000_0404, 32'h0, 32'h0000_1234, 32'h0000_0021});
        chk("addu_valid", 128'(memwr_valid), 128'd1);

        rsp_delay = 4;
        rsp_rdata = 32'h1180_7F22;
        issue({32'h0000_0408, 32'h0, 32'h1000_0102, 32'h8000_0000}, 1, -1, 0, st, rq);
        chk("lb_stalls", 128'(st), 128'd4);
        chk("lb_addr", 128'(cap_addr), 128'h1000_0100);
        chk("lb_be", 128'(cap_be), 128'hF);
        chk("lb_we", 128'(cap_we), 128'd0);
        chk("lb_data", 128'(memwr_reg[95:64]), 128'hFFFF_FF80);
        chk("lb_valid", 128'(memwr_valid), 128'd1);

        issue({32'h0000_040C, 32'h0, 32'h1000_0102, 32'h9000_0000}, 1, -1, 0, st, rq);
        chk("lbu_data", 128'(memwr_reg[95:64]), 128'h0000_0080);
        chk("lbu_valid", 128'(memwr_valid), 128'd1);

        rsp_delay = 2;
        issue({32'h0000_0410, 32'hAABB_CCDD, 32'h0000_0203, 32'hA000_0000}, 1, -1, 0, st, rq);
        chk("sb_stalls", 128'(st), 128'd2);
        chk("sb_we", 128'(cap_we), 128'd1);
        chk("sb_be", 128'(cap_be), 128'b1000);
        chk("sb_wdata", 128'(cap_wdata), 128'hDDDD_DDDD);
        chk("sb_valid", 128'(memwr_valid), 128'd1);
        chk("sb_ldata", 128'(memwr_reg[95:64]), 128'd0);

        rsp_delay = 3;
        ns = n_stores;
        issue({32'h0000_0414, 32'h0102_0304, 32'h0000_0040, 32'hAC00_0000}, 1, 2, 0, st, rq);
        chk("swfl_committed", 128'(n_stores - ns), 128'd1);
        chk("swfl_valid", 128'(memwr_valid), 128'd0);
        issue({32'h0000_0418, 32'h0, 32'h0000_5678, 32'h0000_0021}, 1, -1, 0, st, rq);
        chk("post_fl_valid", 128'(memwr_valid), 128'd1);
        chk("post_fl_alu", 128'(memwr_reg[63:32]), 128'h5678);

        rsp_rand = 1'b1;
        spur_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            w = {$urandom, $urandom, $urandom, ops[$urandom_range(7, 0)], 26'($urandom)};
            issue(w, $urandom_range(3, 0) != 0, -1, 1, st, rq);
        end

        rsp_rand = 1'b0;
        spur_en = 1'b0;
        rsp_delay = 10;
        exmem_reg = {32'h0000_0500, 32'h0, 32'h0000_2000, 32'h8C00_0000};
        exmem_valid = 1'b1;
        @(posedge clk);
        #1;
        exmem_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_req_up", 128'(dmem_req), 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_req", 128'(dmem_req), 128'd0);
        chk("mid_rst_stall", 128'(mem_stall), 128'd0);
        chk("mid_rst_valid", 128'(memwr_valid), 128'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        chk_en = 1'b0;
        rsp_en = 1'b0;
        issue({32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_3000, 32'h8C00_0000}, 1, -1, 0, st, rq);
        chk("to_req_cycles", 128'(rq), 128'(TO));
        chk("to_stalls", 128'(st), 128'(TO));
        chk("to_req", 128'(dmem_req), 128'd0);
        chk("to_err", 128'(mem_err), 128'd1);
        chk("to_valid", 128'(memwr_valid), 128'd0);
        chk("to_ldata", 128'(memwr_reg[95:64]), 128'd0);
        chk("to_stall", 128'(mem_stall), 128'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("to_err_sticky", 128'(mem_err), 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_en = 1'b1;
        chk("to_err_cleared", 128'(mem_err), 128'd0);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
